// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// FSM states, funct3 access encodings and byte write-mask patterns.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] MASK_RD = 4'b0000;
  localparam logic [3:0] MASK_B  = 4'b0001;
  localparam logic [3:0] MASK_H  = 4'b0011;
  localparam logic [3:0] MASK_W  = 4'b1111;

  // Size is carried by funct3[1:0]; bit 2 only selects zero extension.
  function automatic logic f3_is_half(input logic [1:0] f3_lo);
    return f3_lo == 2'b01;
  endfunction

  function automatic logic f3_is_word(input logic [1:0] f3_lo);
    return f3_lo[1];
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: picks the addressed byte/half from a read
// word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] raw_word,
  output logic [31:0] result
);

  logic [7:0]  lanes [4];
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = raw_word[8*gi +: 8];
  end

  assign lane_byte = lanes[offset];
  assign lane_half = offset[1] ? raw_word[31:16] : raw_word[15:0];

  always_comb begin
    result = raw_word;
    if (f3_is_word(funct3[1:0])) begin
      result = raw_word;
    end else if (f3_is_half(funct3[1:0])) begin
      result = funct3[2] ? {16'h0000, lane_half} : {{16{lane_half[15]}}, lane_half};
    end else begin
      result = funct3[2] ? {24'h000000, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine driving the data-cache request/response port.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses are trapped instead of aligned down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              mem_we,
  input  logic              mem_rr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-3:0] mem_req_addr,
  output logic [31:0]       mem_req_data,
  output logic [3:0]        mem_req_write,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              misalign
);

  lsu_state_e state_q, state_d;

  logic              start;
  logic              issue;
  logic [1:0]        off;
  logic [3:0]        mask_new;
  logic [31:0]       data_new;
  logic [31:0]       load_result;

  logic              req_valid_q;
  logic [ADDR_W-3:0] req_addr_q;
  logic [31:0]       req_data_q;
  logic [3:0]        req_write_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_q;
  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic [31:0]       wb_data_q;

  assign start = in_valid & (mem_we | mem_rr) & (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_q;

  assign misaligned = (f3_is_half(funct3[1:0]) & addr[0]) |
                      (f3_is_word(funct3[1:0]) & (addr[1:0] != 2'b00));
  assign off   = addr[1:0];
  assign issue = start & ~misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= start & misaligned;
    end
  end

  assign misalign = misalign_q;
`else
  // Misaligned halves/words are silently aligned down to their natural boundary.
  assign off = f3_is_word(funct3[1:0]) ? 2'b00 :
               f3_is_half(funct3[1:0]) ? {addr[1], 1'b0} : addr[1:0];
  assign issue    = start;
  assign misalign = 1'b0;
`endif

  // Both mem_we and mem_rr high is treated as a store, so mem_we alone decides.
  always_comb begin
    mask_new = MASK_RD;
    data_new = 32'h0;
    if (mem_we) begin
      if (f3_is_word(funct3[1:0])) begin
        mask_new = MASK_W;
        data_new = store_data;
      end else if (f3_is_half(funct3[1:0])) begin
        mask_new = MASK_H << off;
        data_new = {2{store_data[15:0]}};
      end else begin
        mask_new = MASK_B << off;
        data_new = {4{store_data[7:0]}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (issue) state_d = REQ;
      // A non-zero captured mask marks a posted store: no response follows.
      REQ:  if (mem_req_ready) state_d = (req_write_q != MASK_RD) ? IDLE : WAIT;
      WAIT: if (mem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= 32'h0;
      req_write_q <= MASK_RD;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      rd_q        <= 5'd0;
    end else if (issue) begin
      req_valid_q <= 1'b1;
      req_addr_q  <= addr[ADDR_W-1:2];
      req_data_q  <= data_new;
      req_write_q <= mask_new;
      f3_q        <= funct3;
      off_q       <= off;
      rd_q        <= rd;
    end else if ((state_q == REQ) && mem_req_ready) begin
      req_valid_q <= 1'b0;
    end
  end

  lsu_load_align u_load_align (
    .funct3   (f3_q),
    .offset   (off_q),
    .raw_word (mem_resp_data),
    .result   (load_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'h0;
    end else begin
      wb_valid_q <= (state_q == WAIT) & mem_resp_valid;
      if ((state_q == WAIT) && mem_resp_valid) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= load_result;
      end
    end
  end

  assign stall         = start | (state_q != IDLE);
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_data  = req_data_q;
  assign mem_req_write = req_write_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses against an arithmetic model of lane placement and extension.
module tb_load_store_unit;

  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              mem_we;
  logic              mem_rr;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       store_data;
  logic [4:0]        rd;
  logic              stall;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-3:0] mem_req_addr;
  logic [31:0]       mem_req_data;
  logic [3:0]        mem_req_write;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_data;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              misalign;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .mem_we         (mem_we),
    .mem_rr         (mem_rr),
    .funct3         (funct3),
    .addr           (addr),
    .store_data     (store_data),
    .rd             (rd),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_write  (mem_req_write),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .misalign       (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;

  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) acc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int size_of(input logic [2:0] f3);
    int lo;
    lo = int'(f3) % 4;
    if (lo == 0) return 1;
    if (lo == 1) return 2;
    return 4;
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % size_of(f3)) != 0;
  endfunction

  function automatic int model_off(input logic [2:0] f3, input logic [31:0] a);
    int o;
    o = int'(a[1:0]);
    return o - (o % size_of(f3));
  endfunction

  function automatic logic [31:0] model_mask(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << size_of(f3)) - 1) << model_off(f3, a);
    return 32'(m);
  endfunction

  function automatic logic [31:0] model_sdata(input logic [2:0] f3, input logic [31:0] sd);
    longint v;
    if (size_of(f3) == 1) v = longint'(sd % 256) * 64'h01010101;
    else if (size_of(f3) == 2) v = longint'(sd % 65536) * 64'h00010001;
    else v = longint'(sd);
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    longint v;
    longint span;
    int sz;
    sz   = size_of(f3);
    span = longint'(1) << (8 * sz);
    v    = (longint'(w) >> (8 * off)) % span;
    if (sz < 4 && f3 < 3'd4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // One complete access; entered and left at a falling edge with the FSM idle.
  task automatic access(input bit we, input bit rr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rdx, input int rdy_dly,
                        input int resp_dly, input logic [31:0] word);
    int acc0;
    bit is_store;
    is_store = we;
    in_valid = 1'b1; mem_we = we; mem_rr = rr; funct3 = f3;
    addr = a; store_data = sd; rd = rdx;
    #1;
    check("stall_on_start", 32'(stall), 32'd1);
    acc0 = acc_cnt;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; mem_we = $urandom_range(0, 1); mem_rr = $urandom_range(0, 1);
    addr = $urandom; store_data = $urandom; rd = 5'($urandom); funct3 = 3'($urandom);
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (model_mis(f3, a)) begin
      check("mis_pulse", 32'(misalign), 32'd1);
      check("mis_no_req", 32'(mem_req_valid), 32'd0);
      check("mis_stall_low", 32'(stall), 32'd0);
      @(negedge clk); #1;
      check("mis_pulse_end", 32'(misalign), 32'd0);
      check("mis_no_wb", 32'(wb_valid), 32'd0);
      check("mis_no_accept", 32'(acc_cnt - acc0), 32'd0);
      return;
    end
`endif
    $display("access we=%0b rr=%0b f3=%0d addr=0x%08h sd=0x%08h rd=%0d rdy=%0d resp=%0d",
             we, rr, f3, a, sd, rdx, rdy_dly, resp_dly);
    check("wb_pulse_done", 32'(wb_valid), 32'd0);
    check("misalign_low", 32'(misalign), 32'd0);
    for (int i = 0; i <= rdy_dly; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      check("req_valid", 32'(mem_req_valid), 32'd1);
      check("req_addr", 32'(mem_req_addr), a >> 2);
      check("req_write", 32'(mem_req_write), is_store ? model_mask(f3, a) : 32'd0);
      if (is_store) check("req_data", mem_req_data, model_sdata(f3, sd));
      check("stall_req", 32'(stall), 32'd1);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    check("one_accept", 32'(acc_cnt - acc0), 32'd1);
    check("req_dropped", 32'(mem_req_valid), 32'd0);
    if (is_store) begin
      check("store_idle", 32'(stall), 32'd0);
      return;
    end
    for (int i = 0; i < resp_dly; i++) begin
      check("wait_stall", 32'(stall), 32'd1);
      check("wait_no_wb", 32'(wb_valid), 32'd0);
      @(negedge clk); #1;
    end
    mem_resp_valid = 1'b1; mem_resp_data = word;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_resp_data = $urandom;
    #1;
    check("wb_valid", 32'(wb_valid), 32'd1);
    check("wb_rd", 32'(wb_rd), 32'(rdx));
    check("wb_data", wb_data, model_load(f3, model_off(f3, a), word));
    check("load_idle", 32'(stall), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] f3_tab [5];
    int sel;
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

    rst_n = 1'b0; in_valid = 1'b0; mem_we = 1'b0; mem_rr = 1'b0; funct3 = 3'b000;
    addr = '0; store_data = 32'h0; rd = 5'd0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_req_addr", 32'(mem_req_addr), 32'd0);
    check("rst_req_data", mem_req_data, 32'd0);
    check("rst_req_write", 32'(mem_req_write), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Bubbles and unflagged slots never start an access.
    in_valid = 1'b1; mem_we = 1'b0; mem_rr = 1'b0; #1;
    check("bubble_no_stall", 32'(stall), 32'd0);
    in_valid = 1'b0; mem_rr = 1'b1; #1;
    check("invalid_no_stall", 32'(stall), 32'd0);
    @(negedge clk); #1;
    check("bubble_no_req", 32'(mem_req_valid), 32'd0);
    mem_rr = 1'b0;
    @(negedge clk);

    // Directed cases, issued back to back.
    access(1, 0, 3'b000, 32'h1003, 32'h000000AB, 5'd1, 0, 0, 32'h0);
    access(0, 1, 3'b000, 32'h2001, 32'h0, 5'd9, 0, 3, 32'h000080FF);
    access(0, 1, 3'b101, 32'h2002, 32'h0, 5'd12, 1, 0, 32'hBEEF1234);
    access(1, 0, 3'b010, 32'h5000, 32'hCAFEF00D, 5'd3, 4, 0, 32'h0);
    access(1, 1, 3'b001, 32'h6002, 32'h0000A55A, 5'd4, 0, 0, 32'h0);
    access(0, 1, 3'b001, 32'h7002, 32'h0, 5'd5, 0, 1, 32'h8001_7FFF);
    access(0, 1, 3'b010, 32'h3002, 32'h0, 5'd6, 0, 0, 32'h1234_5678);

    // Reset while a load waits for its response; the late response is dropped.
    in_valid = 1'b1; mem_we = 1'b0; mem_rr = 1'b1; funct3 = 3'b010; addr = 32'h4000; rd = 5'd7;
    @(negedge clk);
    in_valid = 1'b0; mem_rr = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; #1;
    check("rstw_stall", 32'(stall), 32'd0);
    check("rstw_req_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
    @(negedge clk);
    mem_resp_valid = 1'b0; #1;
    check("rstw_late_resp_wb", 32'(wb_valid), 32'd0);
    check("rstw_late_resp_stall", 32'(stall), 32'd0);
    access(0, 1, 3'b010, 32'h4004, 32'h0, 5'd8, 0, 0, 32'h0BADF00D);

    // Reset while a store is held in REQ drops mem_req_valid without a clock edge.
    in_valid = 1'b1; mem_we = 1'b1; funct3 = 3'b010; addr = 32'h8000; store_data = 32'h11223344;
    @(negedge clk);
    in_valid = 1'b0; mem_we = 1'b0; #1;
    check("rstr_req_up", 32'(mem_req_valid), 32'd1);
    #2;
    rst_n = 1'b0; #1;
    check("rstr_async_drop", 32'(mem_req_valid), 32'd0);
    check("rstr_addr_clr", 32'(mem_req_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      bit we;
      bit rr;
      sel = $urandom_range(0, 2);
      we  = (sel != 0);
      rr  = (sel != 1);
      access(we, rr, f3_tab[$urandom_range(0, 4)], $urandom, $urandom, 5'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store engine: the responder for the memory read request and memory write-enable flags that the decode stage generates. It accepts one load or store per transaction from the execute/memory pipeline register and drives the data cache's request/response interface. It performs byte-lane alignment, write-mask generation and load sign or zero extension. It stalls the pipeline while a transaction is outstanding and returns load results to writeback.

## Interface
Parameters:
- ADDR_W, 32, byte address width; the cache word address is ADDR_W-2 bits.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  memory-stage slot holds a live instruction (not a bubble).
- mem_we  in  1  instruction is a store.
- mem_rr  in  1  instruction is a load.
- funct3  in  3  access size and signedness: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_W  byte address (ALU result).
- store_data  in  32  rs2 value, unshifted.
- rd  in  5  load destination register.
- stall  out  1  freeze the upstream pipeline.
- mem_req_valid  out  1  cache request valid.
- mem_req_ready  in  1  cache accepts the request.
- mem_req_addr  out  ADDR_W-2  word address.
- mem_req_data  out  32  lane-shifted store data.
- mem_req_write  out  4  byte write mask; 0000 means read.
- mem_resp_valid  in  1  read data is valid.
- mem_resp_data  in  32  read word.
- wb_valid  out  1  one-cycle pulse: load result is ready.
- wb_rd  out  5  destination register for wb_data.
- wb_data  out  32  extended load result.
- misalign  out  1  one-cycle misaligned-access pulse (only with LSU_MISALIGN_TRAP_EN).

## Operation
- FSM states:
  - IDLE: accept a new access.
  - REQ: hold the request until the cache takes it.
  - WAIT: a load waits for its response.
- Start condition: `start = in_valid & (mem_we | mem_rr) & state==IDLE`. mem_we and mem_rr both high is illegal; treat it as a store.
- On start, register addr, funct3, rd, the write mask and the shifted data, then go to REQ.
- REQ: mem_req_valid=1 with stable fields.
  - On `mem_req_valid & mem_req_ready`, a store returns to IDLE. Stores are posted; no response is expected.
  - A load goes to WAIT.
- WAIT: on mem_resp_valid, register wb_data from the captured funct3 and addr[1:0], pulse wb_valid, and return to IDLE.
- Store mask and data, with off = addr[1:0]:
  - SB: mask 0001<<off, data = byte replicated to all 4 lanes.
  - SH: mask 0011<<off, data = half replicated to both halves.
  - SW: mask 1111, data unchanged.
- Load extraction: select the byte at lane off, or the half at lane off[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- mem_resp_valid outside WAIT is ignored.
- stall = start | (state!=IDLE).

## Timing
- Reset values: state IDLE; mem_req_valid, wb_valid, misalign, stall 0; mem_req_addr, mem_req_data, mem_req_write, wb_rd, wb_data all 0.
- Request fields and mem_req_valid are registered. The request is visible the cycle after start.
- Minimum latencies with a ready cache:
  - Store: 1 stall cycle (start) + 1 cycle in REQ.
  - Load: the response arrives no earlier than the cycle after acceptance; wb_valid is high the cycle after mem_resp_valid.
- While mem_req_valid=1 and mem_req_ready=0, all request fields stay constant.
- Back-to-back accesses: the next start is possible in the cycle the FSM is back in IDLE. There is no bubble beyond the FSM return.
- Reset asserted mid-transaction forces IDLE immediately, and mem_req_valid drops asynchronously. A late response arriving after reset is dropped.

## Configuration
- Macro: LSU_MISALIGN_TRAP_EN.
- Misaligned means: H/HU with addr[0]=1, or W with addr[1:0]!=00.
- Defined: a misaligned start issues no request and pulses misalign for one cycle. The FSM stays in IDLE, stall is high only in that cycle, and wb_valid is not pulsed.
- Undefined: offending low address bits are cleared (H to off&2'b10, W to 00) and the access proceeds normally. The misalign port is tied to 0.

## Structure
- Package lsu_pkg holds:
  - the state enum (IDLE/REQ/WAIT);
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - the mask constants.
- Sub-module lsu_load_align (combinational): funct3, offset and raw word in; extended result out. Shared with writeback bypass checks.

## Test plan
- SB at addr 0x1003, store_data 0x000000AB, ready=1 → mem_req_write=1000, mem_req_data=0xABABABAB, mem_req_addr=0x400, then IDLE.
- LB at 0x2001, response 0x0000_80FF after 3 WAIT cycles → wb_data=0xFFFFFF80, wb_valid pulses for 1 cycle with wb_rd matching.
- LHU at 0x2002, response 0xBEEF1234 → wb_data=0x0000BEEF.
- SW with mem_req_ready low for 4 cycles → request fields stable, stall high throughout, one accepted transfer only.
- rst_n low during WAIT, then mem_resp_valid → no wb_valid, stall=0, and the next LW proceeds normally.
- LW at 0x3002:
  - With LSU_MISALIGN_TRAP_EN: misalign pulse, no mem_req_valid.
  - Without: request to word 0xC00 (byte 0x3000).
